// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

    localparam int unsigned MEM_DATA_BITS = 128;
    localparam int unsigned MEM_MASK_BITS = MEM_DATA_BITS / 8;

    // Seed for the optional request-stall LFSR.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {
        IDLE,
        WDATA
    } mem_state_e;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Memory-side request/response bus between a cache (master) and the responder (slave).
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 28
) ();

    logic                     mem_req_val;
    logic                     mem_req_rdy;
    logic [ADDR_BITS-1:0]     mem_req_addr;
    logic                     mem_req_rw;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
    logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
    logic                     mem_resp_val;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;

    modport master (
        output mem_req_val, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data
    );

    modport slave (
        input  mem_req_val, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data
    );

endinterface

// File: rtl/mem_resp_pipe.sv
// Fixed-latency valid/data delay line for read responses.
// LATENCY-1 internal data stages plus an output register; only the valid bits
// and the output data register are cleared by reset.
module mem_resp_pipe #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned WIDTH   = 128
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_val,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_val,
    output logic [WIDTH-1:0] o_data
);

    logic [LATENCY-1:0] r_val;
    logic [WIDTH-1:0]   r_data_out;
    logic [WIDTH-1:0]   w_out_src;

    // Shift valid bits; reset drops every read in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_val <= '0;
        end else begin
            r_val[0] <= i_val;
            for (int i = 1; i < LATENCY; i++) begin
                r_val[i] <= r_val[i-1];
            end
        end
    end

    if (LATENCY > 1) begin : g_stages
        logic [WIDTH-1:0] r_stage [LATENCY-1];

        // Data stages carry no reset; validity is tracked separately.
        always_ff @(posedge i_clk) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < LATENCY - 1; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end

        assign w_out_src = r_stage[LATENCY-2];
    end else begin : g_direct
        assign w_out_src = i_data;
    end

    // Output register, zero while in reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_out_src;
        end
    end

    assign o_val  = r_val[LATENCY-1];
    assign o_data = r_data_out;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: far end of the mem_req_*/mem_resp_* protocol.
// Line-granular reads/writes, byte-masked commits, in-order fixed-latency reads.
// Optional feature: define MEM_RESPONDER_STALL_EN to stall mem_req_rdy pseudo-randomly.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 28,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    mem_state_e              r_state;
    mem_state_e              w_state_next;
    logic [DEPTH_LOG2-1:0]   r_widx;
    logic [MEM_DATA_BITS-1:0] r_mem [Depth];

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_fsm_rdy;
    logic                    w_stall;
    logic                    w_req_fire;
    logic                    w_data_fire;
    logic                    w_commit;
    logic [DEPTH_LOG2-1:0]   w_commit_idx;
    logic                    w_latch;
    logic                    w_rd_push;
    logic [MEM_DATA_BITS-1:0] w_rd_data;
    logic                    w_unused_addr;

    // Upper address bits alias modulo the depth.
    assign w_idx         = bus.mem_req_addr[DEPTH_LOG2-1:0];
    assign w_unused_addr = ^bus.mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign w_fsm_rdy = (r_state == IDLE);

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running stall LFSR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr16_next(r_lfsr);
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Handshakes depend only on state (and stall), never on the valid inputs.
    assign bus.mem_req_rdy        = w_fsm_rdy & ~w_stall;
    assign bus.mem_req_data_ready = 1'b1;

    assign w_req_fire  = bus.mem_req_val & bus.mem_req_rdy;
    assign w_data_fire = bus.mem_req_data_valid & bus.mem_req_data_ready;

    // Next-state, commit and read-push decode.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_commit_idx = w_idx;
        w_latch      = 1'b0;
        w_rd_push    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    if (bus.mem_req_rw) begin
                        if (w_data_fire) begin
                            w_commit = 1'b1;
                        end else begin
                            w_latch      = 1'b1;
                            w_state_next = WDATA;
                        end
                    end else begin
                        w_rd_push = 1'b1;
                    end
                end
            end
            WDATA: begin
                w_commit_idx = r_widx;
                if (w_data_fire) begin
                    w_commit     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state and latched split-write index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_widx  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_widx <= w_idx;
            end
        end
    end

    // Byte-masked line commit; array contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < MEM_MASK_BITS; i++) begin
                if (bus.mem_req_data_mask[i]) begin
                    r_mem[w_commit_idx][8*i +: 8] <= bus.mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    // Array is read in the accept cycle.
    assign w_rd_data = r_mem[w_idx];

    mem_resp_pipe #(
        .LATENCY (LATENCY),
        .WIDTH   (MEM_DATA_BITS)
    ) u_pipe (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_val  (w_rd_push),
        .i_data (w_rd_data),
        .o_val  (bus.mem_resp_val),
        .o_data (bus.mem_resp_data)
    );

endmodule

// File: doc/mem_responder.md
# mem_responder

Main-memory responder for the cache's memory-side port: it is the far end of the `mem_req_*`/`mem_resp_*` protocol. It accepts line-granular read and write requests, stores 128-bit lines in an internal array with byte-masked writes, and returns read data in order after a fixed latency. It serves both as the synthesizable memory backend in FPGA/system builds and as the memory model in cache test benches.

## Interface
- `MEM_DATA_BITS`, 128: line/beat width; the mask is `MEM_DATA_BITS/8` bits.
- `ADDR_BITS`, 28: width of the line address (`mem_req_addr`).
- `DEPTH_LOG2`, 10: the array holds 2**DEPTH_LOG2 lines.
- `LATENCY`, 4: cycles from read accept to response; must be ≥1.
- `clk` in 1: clock. One clock domain only.
- `reset` in 1: reset, asynchronous, active-high.
- `mem_req_val` in 1: request valid.
- `mem_req_rdy` out 1: request ready.
- `mem_req_addr` in ADDR_BITS: line address.
- `mem_req_rw` in 1: 1 = write, 0 = read.
- `mem_req_data_valid` in 1: write data valid.
- `mem_req_data_ready` out 1: write data ready.
- `mem_req_data_bits` in MEM_DATA_BITS: write data.
- `mem_req_data_mask` in MEM_DATA_BITS/8: byte write enables.
- `mem_resp_val` out 1: read response valid, single-cycle pulse.
- `mem_resp_data` out MEM_DATA_BITS: read data.

## Operation
- **Fire rules**
  - Request fire = `mem_req_val & mem_req_rdy`.
  - Data fire = `mem_req_data_valid & mem_req_data_ready`.
- **Indexing:** array index = `mem_req_addr[DEPTH_LOG2-1:0]`. Upper address bits are ignored, so addresses alias modulo the depth.
- **FSM states**
  - IDLE: `mem_req_rdy=1`, `mem_req_data_ready=1`.
    - Read fire: push {valid, data} into the response pipe.
    - Write fire with data fire in the same cycle: commit and stay in IDLE.
    - Write fire without data: latch the index and go to WDATA.
    - Data valid without a write request fire: ignored, nothing written.
  - WDATA: `mem_req_rdy=0`, `mem_req_data_ready=1`.
    - Data fire: commit to the latched index and return to IDLE.
    - Otherwise: hold in WDATA with no timeout.
- **Commit:** byte i of the line is written iff `mask[i]=1`. A mask of all zeros is a legal no-op write.
- **Responses**
  - Writes produce no response.
  - Reads return strictly in accept order.
  - There is no response backpressure. The pipe accepts one read per cycle, so throughput is 1 read/cycle.
- **Read-after-write:** a read accepted in any cycle after the write commit returns the new data.
- **Reset**
  - Clears the FSM to IDLE and clears all pipe valid bits. Reads in flight are dropped, and a half-finished write (in WDATA) is abandoned without being written.
  - Array contents are not reset.
  - Output values during reset:
    - `mem_resp_val=0`, `mem_resp_data=0`.
    - `mem_req_rdy=1` and `mem_req_data_ready=1` (IDLE values, unless the stall LFSR deasserts `mem_req_rdy`).

## Timing
- Read accepted at cycle N → `mem_resp_val=1` with its data at cycle N+LATENCY, for exactly one cycle.
- The array is read in the accept cycle. Data then travels LATENCY-1 register stages plus the output register.
- Combined write (request and data in the same cycle) at cycle N → committed at the N/N+1 edge. The next request can be accepted at N+1.
- Split write → `mem_req_rdy` is low from N+1 until the cycle after data fires.
- Handshake outputs are combinational from state (plus the LFSR when enabled). They never depend on the `*_val` inputs.

## Configuration
- `MEM_RESPONDER_STALL_EN` defined:
  - A 16-bit maximal LFSR (seed 16'hACE1, reset asynchronously) advances every cycle.
  - `mem_req_rdy` is additionally forced low when LFSR[1:0]==2'b00, about 25% of cycles, in IDLE only.
  - `mem_req_data_ready` is never stalled.
  - Ordering and latency relative to accept are unchanged.
- Undefined: the LFSR does not exist, and `mem_req_rdy` follows the FSM only.

## Structure
- Shared package `mem_pkg`:
  - `MEM_DATA_BITS`, derived mask width.
  - FSM state typedef {IDLE, WDATA}.
  - LFSR seed constant.
- Sub-module `mem_resp_pipe`: a parameterized LATENCY-deep valid/data delay line with asynchronous clear of the valid bits.
- The top level holds the FSM, latched write index, array, and optional LFSR.

## Test plan
- **Write then read:** write addr 0x5, data 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0xFFFF, combined beat; read 0x5 → the same data exactly 4 cycles after accept.
- **Masked write:** after the above, write addr 0x5, data all 0xEE, mask 0x0003; read → 0x00112233_44556677_8899AABB_CCDDEEEE.
- **Split write:** request at cycle 10, data at cycle 13 → `mem_req_rdy=0` for cycles 11–13 and 1 at cycle 14; a read of that address then returns the new data.
- **Back-to-back reads:** reads of 0x1, 0x2, 0x3 on consecutive cycles → three consecutive `mem_resp_val` pulses in the same order; aliasing address 0x401 returns the contents of 0x1.
- **Reset mid-operation:** assert `reset` with 2 reads in flight and the FSM in WDATA → no `mem_resp_val` afterwards, state IDLE, the pending write is not committed, and earlier array contents are intact.
- **Stall build (`MEM_RESPONDER_STALL_EN` defined):** 1000 random requests → a scoreboard shows no loss or reordering, and `mem_req_rdy` is low in roughly 20–30% of IDLE cycles.
